// File: rtl/rom_port_arbiter_if.sv
// rtl/rom_port_arbiter_if.sv - requester and ROM-port signal bundle for rom_port_arbiter
// slave is the arbiter side; master is the requester/ROM side.
interface rom_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_data;
    logic [AW-1:0]      addr_a;
    logic [AW-1:0]      addr_b;
    logic [DW-1:0]      q_a;
    logic [DW-1:0]      q_b;

    modport slave (
        input  req_valid, req_addr, q_a, q_b,
        output req_gnt, rsp_valid, rsp_data, addr_a, addr_b
    );

    modport master (
        output req_valid, req_addr, q_a, q_b,
        input  req_gnt, rsp_valid, rsp_data, addr_a, addr_b
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - round-robin arbiter sharing the two dual_port_rom read ports
// Define ROM_ARB_MERGE_EN to also grant requesters whose address matches a chosen port.
module rom_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 32,
    parameter int LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    rom_port_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = IW + 1;

    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]      addr_a_q, addr_a_d;
    logic [AW-1:0]      addr_b_q, addr_b_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NREQ*DW-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0] gnt;
    logic            a_found, b_found;
    logic [IW-1:0]   a_idx, b_idx, last_idx, idx;
    logic [SW-1:0]   pos;

`ifdef ROM_ARB_MERGE_EN
    logic [NREQ-1:0]           a_mask, b_mask;
    logic [LAT-1:0][NREQ-1:0]  pa_mask_q, pa_mask_d, pb_mask_q, pb_mask_d;
`else
    logic [LAT-1:0]            pa_v_q, pa_v_d, pb_v_q, pb_v_d;
    logic [LAT-1:0][IW-1:0]    pa_idx_q, pa_idx_d, pb_idx_q, pb_idx_d;
`endif

    // Scan from rr_ptr; the first valid gets port A, the next eligible one port B.
    always_comb begin
        gnt      = '0;
        a_found  = 1'b0;
        b_found  = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        last_idx = rr_ptr_q;
        idx      = '0;
        pos      = '0;
`ifdef ROM_ARB_MERGE_EN
        a_mask   = '0;
        b_mask   = '0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, rr_ptr_q} + SW'(k);
            if (pos >= SW'(NREQ)) pos = pos - SW'(NREQ);
            idx = pos[IW-1:0];
            if (!rst && bus.req_valid[idx]) begin
                if (!a_found) begin
                    a_found  = 1'b1;
                    a_idx    = idx;
                    gnt[idx] = 1'b1;
                    last_idx = idx;
`ifdef ROM_ARB_MERGE_EN
                    a_mask[idx] = 1'b1;
                end else if (bus.req_addr[idx*AW +: AW] == bus.req_addr[a_idx*AW +: AW]) begin
                    gnt[idx]    = 1'b1;
                    a_mask[idx] = 1'b1;
                    last_idx    = idx;
                end else if (!b_found) begin
                    b_found     = 1'b1;
                    b_idx       = idx;
                    gnt[idx]    = 1'b1;
                    b_mask[idx] = 1'b1;
                    last_idx    = idx;
                end else if (bus.req_addr[idx*AW +: AW] == bus.req_addr[b_idx*AW +: AW]) begin
                    gnt[idx]    = 1'b1;
                    b_mask[idx] = 1'b1;
                    last_idx    = idx;
                end
`else
                end else if (!b_found) begin
                    b_found  = 1'b1;
                    b_idx    = idx;
                    gnt[idx] = 1'b1;
                    last_idx = idx;
                end
`endif
            end
        end
    end

    always_comb begin
        addr_a_d = a_found ? bus.req_addr[a_idx*AW +: AW] : addr_a_q;
        addr_b_d = b_found ? bus.req_addr[b_idx*AW +: AW] : addr_b_q;
        rr_ptr_d = rr_ptr_q;
        if (a_found) rr_ptr_d = (last_idx == IW'(NREQ - 1)) ? '0 : last_idx + 1'b1;
    end

    // In-flight reads shift one stage per cycle; the last stage lines up with ROM q.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
`ifdef ROM_ARB_MERGE_EN
        pa_mask_d    = '0;
        pb_mask_d    = '0;
        pa_mask_d[0] = a_mask;
        pb_mask_d[0] = b_mask;
        for (int s = 1; s < LAT; s++) begin
            pa_mask_d[s] = pa_mask_q[s-1];
            pb_mask_d[s] = pb_mask_q[s-1];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (pa_mask_q[LAT-1][i]) begin
                rsp_valid_d[i]         = 1'b1;
                rsp_data_d[i*DW +: DW] = bus.q_a;
            end
            if (pb_mask_q[LAT-1][i]) begin
                rsp_valid_d[i]         = 1'b1;
                rsp_data_d[i*DW +: DW] = bus.q_b;
            end
        end
`else
        pa_v_d      = '0;
        pb_v_d      = '0;
        pa_idx_d    = '0;
        pb_idx_d    = '0;
        pa_v_d[0]   = a_found;
        pb_v_d[0]   = b_found;
        pa_idx_d[0] = a_idx;
        pb_idx_d[0] = b_idx;
        for (int s = 1; s < LAT; s++) begin
            pa_v_d[s]   = pa_v_q[s-1];
            pb_v_d[s]   = pb_v_q[s-1];
            pa_idx_d[s] = pa_idx_q[s-1];
            pb_idx_d[s] = pb_idx_q[s-1];
        end
        if (pa_v_q[LAT-1]) begin
            rsp_valid_d[pa_idx_q[LAT-1]]         = 1'b1;
            rsp_data_d[pa_idx_q[LAT-1]*DW +: DW] = bus.q_a;
        end
        if (pb_v_q[LAT-1]) begin
            rsp_valid_d[pb_idx_q[LAT-1]]         = 1'b1;
            rsp_data_d[pb_idx_q[LAT-1]*DW +: DW] = bus.q_b;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifdef ROM_ARB_MERGE_EN
            pa_mask_q   <= '0;
            pb_mask_q   <= '0;
`else
            pa_v_q      <= '0;
            pb_v_q      <= '0;
            pa_idx_q    <= '0;
            pb_idx_q    <= '0;
`endif
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef ROM_ARB_MERGE_EN
            pa_mask_q   <= pa_mask_d;
            pb_mask_q   <= pb_mask_d;
`else
            pa_v_q      <= pa_v_d;
            pb_v_q      <= pb_v_d;
            pa_idx_q    <= pa_idx_d;
            pb_idx_q    <= pb_idx_d;
`endif
        end
    end

    // Port addresses go out combinationally so the ROM samples them on the next edge.
    assign bus.req_gnt   = gnt;
    assign bus.addr_a    = addr_a_d;
    assign bus.addr_b    = addr_b_d;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule
